// File: rtl/audio_adc_rx.sv
// WM8731 I2S ADC capture: synchronises the codec pins, deserialises stereo
// frames and queues complete left/right pairs in a first-word-fall-through FIFO.
module audio_adc_rx #(
    parameter int DATA_WIDTH  = 24,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          aud_bclk,
    input  logic                          aud_adclrck,
    input  logic                          aud_adcdat,
    output logic [DATA_WIDTH-1:0]         sample_left,
    output logic [DATA_WIDTH-1:0]         sample_right,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [15:0]                   overflow_count,
    input  logic                          clear_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, WAIT_LEFT, LEFT, RIGHT} state_t;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync, dat_sync;
    logic                   bclk_prev, lrck_q;
    logic                   bclk_s, lrck_s, dat_s;
    logic                   bclk_rise, boundary, shift_en, word_done;
    logic [CW-1:0]          bit_cnt;
    logic [DATA_WIDTH-1:0]  shift_reg, shift_next, left_hold;
    logic                   left_ok, latch_left, push_pair, enter_left;
    logic                   push_req;
    logic [DATA_WIDTH-1:0]  push_left, push_right;

    // NOTE: every flop here uses <= so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
            bclk_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], aud_bclk};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], aud_adclrck};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], aud_adcdat};
            bclk_prev <= bclk_s;
        end
    end

    assign bclk_s     = bclk_sync[SYNC_STAGES-1];
    assign lrck_s     = lrck_sync[SYNC_STAGES-1];
    assign dat_s      = dat_sync[SYNC_STAGES-1];
    assign bclk_rise  = bclk_s & ~bclk_prev;
    assign boundary   = bclk_rise & (lrck_s != lrck_q);
    assign shift_en   = bclk_rise & ~boundary & (bit_cnt < CW'(DATA_WIDTH));
    assign word_done  = shift_en & (bit_cnt == CW'(DATA_WIDTH - 1));
    assign shift_next = {shift_reg[DATA_WIDTH-2:0], dat_s};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // NOTE: a default assignment up front keeps this block free of latches.
    always_comb begin
        next_state = state;
        if (!enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:      next_state = WAIT_LEFT;
                WAIT_LEFT: if (boundary && !lrck_s) next_state = LEFT;
                LEFT:      if (boundary &&  lrck_s) next_state = RIGHT;
                RIGHT:     if (boundary && !lrck_s) next_state = LEFT;
                default:   next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        latch_left = 1'b0;
        push_pair  = 1'b0;
        enter_left = 1'b0;
        if (enable) begin
            latch_left = (state == LEFT) && word_done;
            push_pair  = (state == RIGHT) && word_done && left_ok;
            enter_left = (state == WAIT_LEFT || state == RIGHT) && boundary && !lrck_s;
        end
    end

    // left_ok guards against pushing a pair whose left word was short or missing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lrck_q     <= 1'b0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            left_hold  <= '0;
            left_ok    <= 1'b0;
            push_req   <= 1'b0;
            push_left  <= '0;
            push_right <= '0;
        end else begin
            if (bclk_rise) lrck_q <= lrck_s;
            if (boundary) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                shift_reg <= shift_next;
                bit_cnt   <= bit_cnt + CW'(1);
            end
            if (latch_left) left_hold <= shift_next;
            if (!enable || enter_left || push_pair) left_ok <= 1'b0;
            else if (latch_left)                     left_ok <= 1'b1;
            push_req <= push_pair;
            if (push_pair) begin
                push_left  <= left_hold;
                push_right <= shift_next;
            end
        end
    end

    logic [DATA_WIDTH-1:0] mem_left  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_right [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr, rd_next;
    logic                  full, pop, push_ok, drop;

    assign sample_valid = (fifo_level != '0);
    assign full         = (fifo_level == LW'(FIFO_DEPTH));
    assign pop          = sample_valid & sample_ready;
    assign push_ok      = push_req & (~full | pop);
    assign drop         = push_req & full & ~pop;
    assign rd_next      = rd_ptr + AW'(1);

    // NOTE: storage has no reset; only pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_left[wr_ptr]  <= push_left;
            mem_right[wr_ptr] <= push_right;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            sample_left  <= '0;
            sample_right <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_next;
            if (push_ok && !pop)      fifo_level <= fifo_level + LW'(1);
            else if (pop && !push_ok) fifo_level <= fifo_level - LW'(1);
            // Head registers hold the last value once the FIFO drains.
            if (pop && fifo_level > LW'(1)) begin
                sample_left  <= mem_left[rd_next];
                sample_right <= mem_right[rd_next];
            end else if (push_ok && (pop || fifo_level == '0)) begin
                sample_left  <= push_left;
                sample_right <= push_right;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow       <= 1'b0;
            overflow_count <= '0;
        end else if (clear_overflow) begin
            overflow       <= 1'b0;
            overflow_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (overflow_count != 16'hFFFF) overflow_count <= overflow_count + 16'd1;
        end
    end
endmodule
